// File: rtl/three_color_light_pkg.sv
// Shared definitions for the three-colour indicator controller.
//   mode_e          : six colour modes, 3-bit encoding 0..5
//   LED_*           : bit positions inside the 4-bit LED output
//   *_DEF           : default timing parameters for a 50 MHz clock
//   mode_next/prev  : cyclic mode stepping
//   mode_leds       : colour LED pattern for a mode and blink phase
package three_color_light_pkg;

  localparam int unsigned DEBOUNCE_CYCLES_DEF = 50_000;      // 1 ms
  localparam int unsigned BLINK_HALF_DEF      = 12_500_000;  // 0.25 s

  localparam int unsigned LED_RED   = 0;
  localparam int unsigned LED_GREEN = 1;
  localparam int unsigned LED_BLUE  = 2;
  localparam int unsigned LED_IND   = 3;

  typedef enum logic [2:0] {
    MODE_OFF   = 3'd0,
    MODE_RED   = 3'd1,
    MODE_GREEN = 3'd2,
    MODE_BLUE  = 3'd3,
    MODE_WHITE = 3'd4,
    MODE_FLASH = 3'd5
  } mode_e;

  function automatic mode_e mode_next(input mode_e m);
    case (m)
      MODE_OFF:   return MODE_RED;
      MODE_RED:   return MODE_GREEN;
      MODE_GREEN: return MODE_BLUE;
      MODE_BLUE:  return MODE_WHITE;
      MODE_WHITE: return MODE_FLASH;
      default:    return MODE_OFF;
    endcase
  endfunction

  function automatic mode_e mode_prev(input mode_e m);
    case (m)
      MODE_OFF:   return MODE_FLASH;
      MODE_RED:   return MODE_OFF;
      MODE_GREEN: return MODE_RED;
      MODE_BLUE:  return MODE_GREEN;
      MODE_WHITE: return MODE_BLUE;
      default:    return MODE_WHITE;
    endcase
  endfunction

  function automatic logic [2:0] mode_leds(input mode_e m, input logic blink);
    logic [2:0] l;
    l = '0;
    case (m)
      MODE_RED:   l[LED_RED]   = 1'b1;
      MODE_GREEN: l[LED_GREEN] = 1'b1;
      MODE_BLUE:  l[LED_BLUE]  = 1'b1;
      MODE_WHITE: l = '1;
      MODE_FLASH: l = {3{blink}};
      default:    l = '0;
    endcase
    return l;
  endfunction

endpackage

// File: rtl/three_color_light_key_debounce.sv
// Per-key input conditioning: two-flop synchroniser, debounce counter and a
// one-cycle pulse on the debounced rising edge.
//   clk_i   : clock
//   rst_ni  : synchronous active-low reset
//   key_i   : raw asynchronous key level, active-high
//   press_o : one-cycle pulse when the debounced level goes 0->1
module key_debounce
  import three_color_light_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic key_i,
  output logic press_o
);

  localparam int unsigned CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync1_q, sync2_q;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          level_q, level_d;
  logic          press_q, press_d;

  // The counter only runs while the synchronised level disagrees with the
  // accepted level; any agreement restarts it, so short glitches never land.
  always_comb begin
    cnt_d   = cnt_q;
    level_d = level_q;
    if (sync2_q == level_q) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_LAST) begin
      level_d = sync2_q;
      cnt_d   = '0;
    end else begin
      cnt_d = cnt_q + CW'(1);
    end
    press_d = level_d & ~level_q;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      cnt_q   <= '0;
      level_q <= 1'b0;
      press_q <= 1'b0;
    end else begin
      sync1_q <= key_i;
      sync2_q <= sync1_q;
      cnt_q   <= cnt_d;
      level_q <= level_d;
      press_q <= press_d;
    end
  end

  assign press_o = press_q;

endmodule

// File: rtl/three_color_light.sv
// Three-colour indicator controller: two debounced buttons step a six-mode
// colour machine; LED[3] toggles on every accepted single press.
//   Sys_CLK : 50 MHz clock, rising edge
//   Sys_RST : synchronous active-low reset
//   Key[0]  : next mode, Key[1] : previous mode (active-high)
//   LED     : registered, active-high; [0] red [1] green [2] blue [3] press
module three_color_light
  import three_color_light_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
  parameter int unsigned BLINK_HALF      = BLINK_HALF_DEF
) (
  input  logic       Sys_CLK,
  input  logic       Sys_RST,
  input  logic [1:0] Key,
  output logic [3:0] LED
);

  localparam int unsigned BW = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_HALF - 1);

  logic press_next, press_prev;

  key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_key_next (
    .clk_i   (Sys_CLK),
    .rst_ni  (Sys_RST),
    .key_i   (Key[0]),
    .press_o (press_next)
  );

  key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_key_prev (
    .clk_i   (Sys_CLK),
    .rst_ni  (Sys_RST),
    .key_i   (Key[1]),
    .press_o (press_prev)
  );

  mode_e         mode_q, mode_d;
  logic [BW-1:0] blink_cnt_q, blink_cnt_d;
  logic          blink_q, blink_d;
  logic [3:0]    led_q, led_d;
  logic          ind_d;

  always_comb begin
    mode_d = mode_q;
    ind_d  = led_q[LED_IND];
    if (press_next ^ press_prev) begin
      mode_d = press_next ? mode_next(mode_q) : mode_prev(mode_q);
      ind_d  = ~led_q[LED_IND];
    end

    // Held at count 0 / phase lit outside FLASH, so entry starts lit.
    if (mode_q != MODE_FLASH) begin
      blink_cnt_d = '0;
      blink_d     = 1'b1;
    end else if (blink_cnt_q == BLINK_LAST) begin
      blink_cnt_d = '0;
      blink_d     = ~blink_q;
    end else begin
      blink_cnt_d = blink_cnt_q + BW'(1);
      blink_d     = blink_q;
    end

    // LEDs are computed from next-state so they change with the mode register.
    led_d = {ind_d, mode_leds(mode_d, blink_d)};
  end

  always_ff @(posedge Sys_CLK) begin
    if (!Sys_RST) begin
      mode_q      <= MODE_OFF;
      blink_cnt_q <= '0;
      blink_q     <= 1'b1;
      led_q       <= '0;
    end else begin
      mode_q      <= mode_d;
      blink_cnt_q <= blink_cnt_d;
      blink_q     <= blink_d;
      led_q       <= led_d;
    end
  end

  assign LED = led_q;

endmodule

// File: tb/tb_three_color_light.sv
module tb_three_color_light;

  localparam int unsigned D  = 4;
  localparam int unsigned BH = 10;

  logic       Sys_CLK = 1'b0;
  logic       Sys_RST = 1'b0;
  logic [1:0] Key     = 2'b00;
  logic [3:0] LED;

  int checks = 0;
  int errors = 0;

  three_color_light #(.DEBOUNCE_CYCLES(D), .BLINK_HALF(BH)) dut (
    .Sys_CLK (Sys_CLK),
    .Sys_RST (Sys_RST),
    .Key     (Key),
    .LED     (LED)
  );

  always #10 Sys_CLK = ~Sys_CLK;

  // Inputs as seen by the DUT at each rising edge.
  logic [1:0] key_s = 2'b00;
  logic       rst_s = 1'b0;
  always @(posedge Sys_CLK) begin
    key_s <= Key;
    rst_s <= Sys_RST;
  end

  function automatic logic [2:0] colour(input int m, input bit lit);
    case (m)
      0: return 3'b000;
      1: return 3'b001;
      2: return 3'b010;
      3: return 3'b100;
      4: return 3'b111;
      default: return lit ? 3'b111 : 3'b000;
    endcase
  endfunction

  // Reference model: a key level is accepted once the raw samples taken two
  // to D+1 edges ago all show the opposite value; mode is an integer 0..5
  // stepped modulo 6; blink phase follows from the time spent in FLASH.
  int         m_mode = 0;
  int         m_prev_mode;
  bit         m_ind = 0;
  int         m_age = 0;
  bit [1:0]   m_lvl = '0;
  bit [1:0]   m_pend = '0;
  bit [D+1:0] m_hist [2];
  bit         all_opp;
  logic [3:0] m_led;

  initial begin
    m_hist[0] = '0;
    m_hist[1] = '0;
    forever begin
      @(negedge Sys_CLK);
      if (!rst_s) begin
        m_mode = 0; m_ind = 0; m_age = 0; m_lvl = '0; m_pend = '0;
        m_hist[0] = '0; m_hist[1] = '0;
      end else begin
        m_prev_mode = m_mode;
        if (m_pend[0] != m_pend[1]) begin
          m_mode = m_pend[0] ? (m_mode + 1) % 6 : (m_mode + 5) % 6;
          m_ind  = !m_ind;
        end
        if (m_mode == 5) m_age = (m_prev_mode == 5) ? m_age + 1 : 0;
        for (int k = 0; k < 2; k++) begin
          m_hist[k] = {m_hist[k][D:0], key_s[k]};
          all_opp = 1'b1;
          for (int i = 2; i <= int'(D) + 1; i++)
            if (m_hist[k][i] == m_lvl[k]) all_opp = 1'b0;
          m_pend[k] = 1'b0;
          if (all_opp) begin
            m_lvl[k]  = !m_lvl[k];
            m_pend[k] = m_lvl[k];
          end
        end
      end
      m_led = {m_ind, colour(m_mode, ((m_age / int'(BH)) % 2) == 0)};
      checks++;
      if (LED !== m_led) begin
        errors++;
        $display("FAIL model t=%0t LED=%b expected=%b", $time, LED, m_led);
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge Sys_CLK);
    #2;
  endtask

  task automatic chk(input string name, input logic [3:0] exp);
    checks++;
    if (LED !== exp) begin
      errors++;
      $display("FAIL %s: LED=%b expected=%b", name, LED, exp);
    end
  endtask

  task automatic press_chk(input logic [1:0] k, input string name, input logic [3:0] exp);
    Key = k;
    step(12);
    chk(name, exp);
    Key = 2'b00;
    step(12);
  endtask

  task automatic do_reset();
    Sys_RST = 1'b0;
    step(2);
    Sys_RST = 1'b1;
    step(5);
  endtask

  initial begin
    // Reset with next key held: one step after release, no repeat.
    Sys_RST = 1'b0;
    Key = 2'b01;
    for (int i = 0; i < 5; i++) begin
      step(1);
      chk("reset", 4'b0000);
    end
    Sys_RST = 1'b1;
    step(10);
    chk("held_through_reset", 4'b1001);
    step(20);
    chk("no_autorepeat", 4'b1001);
    Key = 2'b00;
    step(10);
    chk("release_no_step", 4'b1001);

    // Press latency: mode lands D+3 edges after the key is first sampled.
    Key = 2'b01;
    step(6);
    chk("latency_before", 4'b1001);
    step(1);
    chk("latency_after", 4'b0010);
    Key = 2'b00;
    step(12);

    // Forward cycle with wrap.
    do_reset();
    press_chk(2'b01, "fwd_red",   4'b1001);
    press_chk(2'b01, "fwd_green", 4'b0010);
    press_chk(2'b01, "fwd_blue",  4'b1100);
    press_chk(2'b01, "fwd_white", 4'b0111);
    press_chk(2'b01, "fwd_flash_lit", 4'b1111);
    chk("flash_dark", 4'b1000);
    step(3);
    chk("flash_relit", 4'b1111);
    step(9);
    chk("flash_lit_end", 4'b1111);
    step(1);
    chk("flash_dark_start", 4'b1000);
    step(30);
    press_chk(2'b01, "fwd_wrap_off", 4'b0000);

    // Backward with wrap.
    press_chk(2'b10, "prev_wrap_flash", 4'b1111);
    press_chk(2'b10, "prev_white", 4'b0111);

    // Bounce and glitch rejection.
    do_reset();
    for (int i = 0; i < 25; i++) begin
      Key[0] = ~Key[0];
      step(2);
    end
    Key = 2'b00;
    step(12);
    chk("bounce", 4'b0000);
    Key = 2'b01;
    step(D - 1);
    Key = 2'b00;
    step(12);
    chk("glitch_short", 4'b0000);
    Key = 2'b01;
    step(D);
    Key = 2'b00;
    step(12);
    chk("glitch_exact", 4'b1001);

    // Both keys together.
    Key = 2'b11;
    step(20);
    chk("both_held", 4'b1001);
    Key = 2'b00;
    step(12);
    chk("both_released", 4'b1001);

    // Into FLASH, dwell, and leave to OFF.
    press_chk(2'b01, "to_green", 4'b0010);
    press_chk(2'b01, "to_blue",  4'b1100);
    press_chk(2'b01, "to_white", 4'b0111);
    press_chk(2'b01, "to_flash", 4'b1111);
    step(60);
    press_chk(2'b01, "flash_exit_off", 4'b0000);
    step(5);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/three_color_light.md
Name: three_color_light

Overview:
- Top-level controller for a three-colour (RGB) indicator driven by two push-buttons.
- Each button is synchronised and debounced; a debounced press steps a six-state colour-mode machine forward or backward.
- The mode machine drives three colour LEDs plus one press-indicator LED.
- Runs on the 50 MHz board clock.

Parameters:
- DEBOUNCE_CYCLES, 50_000: consecutive stable cycles needed to accept a key level change (1 ms at 50 MHz).
- BLINK_HALF, 12_500_000: half-period in cycles of the FLASH-mode blink (0.25 s).

Ports:
- Sys_CLK  input  1  system clock, 50 MHz, all logic on the rising edge.
- Sys_RST  input  1  reset, synchronous, active-low.
- Key  input  2  push-buttons, active-high (1 = pressed). Key[0] = next mode, Key[1] = previous mode.
- LED  output  4  active-high (1 = lit), registered. LED[0] red, LED[1] green, LED[2] blue, LED[3] press indicator.

Behaviour:
- Interface: one clock; reset is synchronous and active-low.
- Reset (Sys_RST=0 sampled on a clock edge) clears:
  - synchronisers, debounce counters and debounced levels;
  - mode = OFF, blink counter = 0, blink phase = 1;
  - LED = 4'b0000.
- Reset mid-operation aborts any pending debounce; a key held through reset release is accepted as a new press once stable.
- Per-key input path:
  - two-flop synchroniser;
  - counter, cleared whenever the synchronised level equals the debounced level;
  - when the levels differ, the counter increments; on reaching DEBOUNCE_CYCLES-1 the debounced level takes the new value and the counter clears;
  - a one-cycle press pulse is generated on the debounced 0->1 edge.
- Glitches shorter than DEBOUNCE_CYCLES never change the debounced level. Release edges produce no pulse.
- Latency: press pulse asserts DEBOUNCE_CYCLES+2 cycles after the Key rise (±1). The mode register and LED update on the cycle after the pulse.
- Modes and LED[2:0]:
  - OFF = 000
  - RED = 001
  - GREEN = 010
  - BLUE = 100
  - WHITE = 111
  - FLASH = {3{blink}}
- Next-mode pulse: OFF->RED->GREEN->BLUE->WHITE->FLASH->OFF (wraps).
- Previous-mode pulse: reverse order; OFF wraps to FLASH.
- Both pulses in the same cycle: mode unchanged, LED[3] unchanged.
- LED[3] toggles once for every accepted single press (either key).
- FLASH mode:
  - on entry, blink counter = 0 and blink = 1, so LEDs are lit immediately;
  - the counter counts 0..BLINK_HALF-1, then wraps and toggles blink;
  - outside FLASH the counter is held at 0.
- Held key: exactly one step per press, no auto-repeat.
- All mode and blink widths are sized from the parameters; counters never overflow (compare-and-clear).

Decomposition:
- Shared package holds:
  - mode enum (OFF, RED, GREEN, BLUE, WHITE, FLASH; 3-bit encoding 0..5);
  - LED bit-index constants;
  - default values for DEBOUNCE_CYCLES and BLINK_HALF.
- One natural sub-module: key_debounce (synchroniser, debounce and rising-edge pulse), parameterised by DEBOUNCE_CYCLES and instantiated once per key.
- Mode FSM, blink generator and LED register stay in the top level.

Test Plan (50 MHz clock, default parameters unless noted):
- Reset: hold Sys_RST=0 for 5 cycles with Key=2'b01 -> LED=0000 throughout reset; after release with the key still held, exactly one step to RED after ~1 ms.
- Forward cycle: Sys_RST=1, Key=0 for 1 ms, then five pulses of Key=2'b01 (2 ms high, 2 ms low).
  - LED goes 0000 -> 1001 -> 0010 -> 1100 -> 0111 -> FLASH with LED[3]=1.
  - Each step lands ~1 ms after the corresponding rise.
- Backward and wrap:
  - from OFF, a Key=2'b10 press -> FLASH;
  - another -> WHITE (x111);
  - six Key=2'b01 presses from OFF -> back to OFF, LED[3] toggled six times.
- Bounce rejection: Key[0] toggling every 10 µs for 500 µs, then low -> no mode change, no LED[3] toggle.
- Simultaneous: Key 2'b00 -> 2'b11 in one step, held 2 ms -> mode and LED unchanged.
- Flash timing (BLINK_HALF=10, DEBOUNCE_CYCLES=4): enter FLASH -> LED[2:0]=111 for 10 cycles, 000 for 10 cycles, repeating; a next press returns to OFF with LED[2:0]=000.
